// File: rtl/logit_argmax_classifier_if.sv
// Logit stream in, argmax result out. Optional ARGMAX_HEX_EN adds hex_o.
interface logit_argmax_classifier_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 4
);
    logic                  start_i;
    logic                  logit_valid_i;
    logic [DATA_WIDTH-1:0] logit_i;
    logic                  logit_last_i;
    logic                  logit_ready_o;
    logic                  class_valid_o;
    logic [IDX_WIDTH-1:0]  class_o;
    logic [DATA_WIDTH-1:0] max_logit_o;
    logic                  length_error_o;
    logic                  busy_o;
    logic                  result_ack_i;
`ifdef ARGMAX_HEX_EN
    logic [6:0]            hex_o;
`endif

    modport slave (
        input  start_i, logit_valid_i, logit_i, logit_last_i, result_ack_i,
        output logit_ready_o, class_valid_o, class_o, max_logit_o,
               length_error_o, busy_o
`ifdef ARGMAX_HEX_EN
        , output hex_o
`endif
    );

    modport master (
        output start_i, logit_valid_i, logit_i, logit_last_i, result_ack_i,
        input  logit_ready_o, class_valid_o, class_o, max_logit_o,
               length_error_o, busy_o
`ifdef ARGMAX_HEX_EN
        , input hex_o
`endif
    );
endinterface

// File: rtl/logit_argmax_classifier.sv
// Running argmax over one logit vector; result valid 1 cycle after the final beat, held until acked.
// Ready only in COLLECT; start is honoured only in IDLE. ARGMAX_HEX_EN adds a registered 7-seg hex_o.
module logit_argmax_classifier #(
    parameter int DATA_WIDTH = 32,
    parameter int N_NEURONS  = 10,
    parameter int IDX_WIDTH  = 4
) (
    input logic                     system_clock,
    input logic                     global_reset,
    logit_argmax_classifier_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DONE = 2'd2} state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_NEURONS - 1);

    state_t                state, state_next;
    logic [IDX_WIDTH-1:0]  cnt, cnt_d;
    logic [IDX_WIDTH-1:0]  best_idx, best_idx_d;
    logic [DATA_WIDTH-1:0] best_val, best_val_d;
    logic                  len_err, len_err_d;
    logic                  beat;
    logic                  final_beat;

    assign beat       = (state == COLLECT) && bus.logit_valid_i;
    assign final_beat = beat && (bus.logit_last_i || (cnt == LAST_IDX));

    always_ff @(posedge system_clock or posedge global_reset) begin
        if (global_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ack wins over a simultaneous start in DONE; the producer must re-issue start.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start_i)      state_next = COLLECT;
            COLLECT: if (final_beat)       state_next = DONE;
            DONE:    if (bus.result_ack_i) state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt;
        best_idx_d = best_idx;
        best_val_d = best_val;
        len_err_d  = len_err;
        if ((state == IDLE) && bus.start_i) begin
            cnt_d     = '0;
            len_err_d = 1'b0;
        end else if (beat) begin
            if (cnt == '0) begin
                best_val_d = bus.logit_i;
                best_idx_d = '0;
            end else if ($signed(bus.logit_i) > $signed(best_val)) begin
                best_val_d = bus.logit_i;
                best_idx_d = cnt;
            end
            if (cnt != LAST_IDX) begin
                cnt_d = cnt + 1'b1;
            end
            if (final_beat) begin
                len_err_d = (bus.logit_last_i && (cnt != LAST_IDX)) ||
                            (!bus.logit_last_i && (cnt == LAST_IDX));
            end
        end
    end

    always_ff @(posedge system_clock or posedge global_reset) begin
        if (global_reset) begin
            cnt      <= '0;
            best_idx <= '0;
            best_val <= '0;
            len_err  <= 1'b0;
        end else begin
            cnt      <= cnt_d;
            best_idx <= best_idx_d;
            best_val <= best_val_d;
            len_err  <= len_err_d;
        end
    end

    always_comb begin
        bus.logit_ready_o  = (state == COLLECT);
        bus.busy_o         = (state != IDLE);
        bus.class_valid_o  = (state == DONE);
        bus.class_o        = best_idx;
        bus.max_logit_o    = best_val;
        bus.length_error_o = len_err;
    end

`ifdef ARGMAX_HEX_EN
    logic [3:0] hex_nib;
    logic [6:0] hex_d;

    assign hex_nib = 4'(best_idx_d);

    // Active-low segments ordered {g,f,e,d,c,b,a}; driven from next-state so it tracks class_valid_o.
    always_comb begin
        hex_d = 7'b0111111;
        if (state_next == DONE) begin
            case (hex_nib)
                4'h0: hex_d = 7'b1000000;
                4'h1: hex_d = 7'b1111001;
                4'h2: hex_d = 7'b0100100;
                4'h3: hex_d = 7'b0110000;
                4'h4: hex_d = 7'b0011001;
                4'h5: hex_d = 7'b0010010;
                4'h6: hex_d = 7'b0000010;
                4'h7: hex_d = 7'b1111000;
                4'h8: hex_d = 7'b0000000;
                4'h9: hex_d = 7'b0010000;
                4'hA: hex_d = 7'b0001000;
                4'hB: hex_d = 7'b0000011;
                4'hC: hex_d = 7'b1000110;
                4'hD: hex_d = 7'b0100001;
                4'hE: hex_d = 7'b0000110;
                default: hex_d = 7'b0001110;
            endcase
        end
    end

    always_ff @(posedge system_clock or posedge global_reset) begin
        if (global_reset) begin
            bus.hex_o <= 7'b0111111;
        end else begin
            bus.hex_o <= hex_d;
        end
    end
`endif

endmodule

// File: tb/tb_logit_argmax_classifier.sv
// Directed bench for logit_argmax_classifier with hand-computed expected results.
module tb_logit_argmax_classifier;
    logic system_clock = 1'b0;
    logic global_reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] v [0:9];

    logit_argmax_classifier_if #(.DATA_WIDTH(32), .IDX_WIDTH(4)) bus ();

    logit_argmax_classifier #(.DATA_WIDTH(32), .N_NEURONS(10), .IDX_WIDTH(4)) dut (
        .system_clock(system_clock),
        .global_reset(global_reset),
        .bus         (bus.slave)
    );

    always #5 system_clock = ~system_clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge system_clock);
        #1;
    endtask

    task automatic pulse_start();
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic ack();
        bus.result_ack_i = 1'b1;
        tick();
        bus.result_ack_i = 1'b0;
    endtask

    // Sends v[first..stop-1]; last flag on index last_at (-1 = never).
    task automatic send(input int first, input int stop, input int last_at, input bit gaps);
        for (int i = first; i < stop; i++) begin
            if (gaps) begin
                bus.logit_valid_i = 1'b0;
                bus.logit_last_i  = 1'b0;
                tick();
            end
            chk("ready_in_collect", 32'(bus.logit_ready_o), 32'd1);
            bus.logit_valid_i = 1'b1;
            bus.logit_i       = v[i];
            bus.logit_last_i  = (i == last_at);
            tick();
        end
        bus.logit_valid_i = 1'b0;
        bus.logit_last_i  = 1'b0;
        bus.logit_i       = '0;
    endtask

    task automatic chk_result(input string tag, input logic [3:0] cls, input logic [31:0] mx,
                              input logic lerr);
        chk({tag, "_valid"}, 32'(bus.class_valid_o), 32'd1);
        chk({tag, "_class"}, 32'(bus.class_o), 32'(cls));
        chk({tag, "_max"}, bus.max_logit_o, mx);
        chk({tag, "_lenerr"}, 32'(bus.length_error_o), 32'(lerr));
        chk({tag, "_ready"}, 32'(bus.logit_ready_o), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy_o), 32'd1);
    endtask

    task automatic load_base();
        v = '{32'h00000654, 32'h00002bd9, 32'hfffffaa6, 32'hffffefba, 32'hffffedcb,
              32'hfffff75a, 32'hfffff8f2, 32'h000008c6, 32'h000000f7, 32'h000001da};
    endtask

    initial begin
        bus.start_i       = 1'b0;
        bus.logit_valid_i = 1'b0;
        bus.logit_i       = '0;
        bus.logit_last_i  = 1'b0;
        bus.result_ack_i  = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(bus.class_valid_o), 32'd0);
        chk("rst_ready", 32'(bus.logit_ready_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_class", 32'(bus.class_o), 32'd0);
        chk("rst_max", bus.max_logit_o, 32'd0);
        chk("rst_lenerr", 32'(bus.length_error_o), 32'd0);
`ifdef ARGMAX_HEX_EN
        chk("rst_hex", 32'(bus.hex_o), 32'b0111111);
`endif
        global_reset = 1'b0;
        tick();
        chk("idle_busy", 32'(bus.busy_o), 32'd0);

        // Reference vector: maximum 0x2bd9 at index 1
        load_base();
        pulse_start();
        chk("collect_busy", 32'(bus.busy_o), 32'd1);
        send(0, 10, 9, 1'b0);
        chk_result("vec_base", 4'd1, 32'h00002bd9, 1'b0);
        ack();
        chk("ack_valid_drop", 32'(bus.class_valid_o), 32'd0);
        chk("ack_busy_drop", 32'(bus.busy_o), 32'd0);
        chk("ack_class_kept", 32'(bus.class_o), 32'd1);
        chk("ack_max_kept", bus.max_logit_o, 32'h00002bd9);

        // All equal: lowest index wins
        for (int i = 0; i < 10; i++) v[i] = 32'hffff0000;
        pulse_start();
        send(0, 10, 9, 1'b0);
        chk_result("tie", 4'd0, 32'hffff0000, 1'b0);
        ack();

        // Extreme negative values, winner at the final index
        for (int i = 0; i < 9; i++) v[i] = 32'h80000000;
        v[9] = 32'h80000001;
        pulse_start();
        send(0, 10, 9, 1'b0);
        chk_result("minneg", 4'd9, 32'h80000001, 1'b0);
        ack();

        // Gapped input, delayed ack, then start+ack collision
        load_base();
        pulse_start();
        send(0, 10, 9, 1'b1);
        chk_result("gapped", 4'd1, 32'h00002bd9, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_result("hold", 4'd1, 32'h00002bd9, 1'b0);
        end
        bus.start_i      = 1'b1;
        bus.result_ack_i = 1'b1;
        tick();
        bus.start_i      = 1'b0;
        bus.result_ack_i = 1'b0;
        chk("startack_valid", 32'(bus.class_valid_o), 32'd0);
        chk("startack_busy", 32'(bus.busy_o), 32'd0);
        tick();
        chk("startack_dropped", 32'(bus.busy_o), 32'd0);

        // Early last on beat 6
        pulse_start();
        send(0, 7, 6, 1'b0);
        chk_result("short", 4'd1, 32'h00002bd9, 1'b1);
        ack();

        // Ten beats without last
        pulse_start();
        send(0, 10, -1, 1'b0);
        chk_result("nolast", 4'd1, 32'h00002bd9, 1'b1);
        ack();

        // Clean run after an error clears the length error
        pulse_start();
        send(0, 10, 9, 1'b0);
        chk_result("clean_after_err", 4'd1, 32'h00002bd9, 1'b0);
        ack();

        // Reset mid-collection discards the partial vector
        for (int i = 0; i < 10; i++) v[i] = 32'h7fffffff;
        pulse_start();
        send(0, 4, -1, 1'b0);
        global_reset = 1'b1;
        #1;
        chk("midrst_valid", 32'(bus.class_valid_o), 32'd0);
        chk("midrst_ready", 32'(bus.logit_ready_o), 32'd0);
        chk("midrst_busy", 32'(bus.busy_o), 32'd0);
        chk("midrst_class", 32'(bus.class_o), 32'd0);
        chk("midrst_max", bus.max_logit_o, 32'd0);
        chk("midrst_lenerr", 32'(bus.length_error_o), 32'd0);
        tick();
        global_reset = 1'b0;
        tick();
        chk("midrst_idle", 32'(bus.busy_o), 32'd0);

        // Restart; a start pulse mid-collection must be ignored
        load_base();
        pulse_start();
        send(0, 5, -1, 1'b0);
        pulse_start();
        chk("restart_ignored_busy", 32'(bus.busy_o), 32'd1);
        send(5, 10, 9, 1'b0);
        chk_result("restart", 4'd1, 32'h00002bd9, 1'b0);
        ack();

        // Winner at index 7
        load_base();
        v[7] = 32'h00007000;
        pulse_start();
        send(0, 10, 9, 1'b0);
        chk_result("idx7", 4'd7, 32'h00007000, 1'b0);
`ifdef ARGMAX_HEX_EN
        chk("hex_seven", 32'(bus.hex_o), 32'b1111000);
`endif
        ack();
`ifdef ARGMAX_HEX_EN
        chk("hex_dash_after_ack", 32'(bus.hex_o), 32'b0111111);
`endif
        chk("idx7_done_idle", 32'(bus.class_valid_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/logit_argmax_classifier.md
Name: logit_argmax_classifier

Overview:
Sequential classifier stage placed directly downstream of the fully connected layer. It accepts the N_NEURONS signed fixed-point logits one beat at a time over a valid/ready stream, tracks the running maximum, and presents the winning class index and its logit. The result is held until the consumer acknowledges it; the consumer is the board LED/HEX logic or the output RAM writer.

Parameters:
DATA_WIDTH, 32, logit width in bits, two's complement (Q16.16 in the current network; no fractional handling is needed here)
N_NEURONS, 10, number of logits per inference; legal range 2..2^IDX_WIDTH
IDX_WIDTH, 4, width of class index; must satisfy 2^IDX_WIDTH >= N_NEURONS

Ports:
system_clock  in  1  clock
global_reset  in  1  asynchronous, active-high reset
start_i  in  1  single-cycle pulse that arms collection of one logit vector
logit_valid_i  in  1  logit_i and logit_last_i are valid this cycle
logit_i  in  DATA_WIDTH  signed logit
logit_last_i  in  1  marks the final logit of the vector
logit_ready_o  out  1  block accepts a beat this cycle
class_valid_o  out  1  result valid; held until acknowledged
class_o  out  IDX_WIDTH  index of the maximum logit
max_logit_o  out  DATA_WIDTH  value of the maximum logit
length_error_o  out  1  vector length did not match N_NEURONS; valid while class_valid_o is high
busy_o  out  1  state is not IDLE
result_ack_i  in  1  consumer takes the result

Behaviour:
- Reset is asynchronous, active-high, on global_reset; clock is system_clock. All outputs reset to 0 and the state resets to IDLE. A reset asserted mid-collection discards the partial vector; no result is produced.
- States: IDLE, COLLECT, DONE. Only the registered state and counters are used; outputs are decoded from registers.
- IDLE:
  - logit_ready_o=0, busy_o=0.
  - start_i=1 -> COLLECT; beat counter cnt=0; length_error cleared.
- COLLECT:
  - logit_ready_o=1, busy_o=1. A beat is accepted on a cycle where logit_valid_i & logit_ready_o.
  - Beat with cnt==0: best_val<=logit_i, best_idx<=0, loaded unconditionally.
  - Beat with cnt>0: if $signed(logit_i) > $signed(best_val), then best_val<=logit_i and best_idx<=cnt.
  - The comparison is strict, so on ties the lowest index wins.
  - cnt increments per accepted beat and saturates at N_NEURONS-1.
  - Transition to DONE happens on an accepted beat when logit_last_i=1 OR cnt==N_NEURONS-1.
  - length_error is set on that final beat if logit_last_i=1 with cnt!=N_NEURONS-1, or if cnt==N_NEURONS-1 with logit_last_i=0.
  - start_i is ignored while in COLLECT.
- DONE:
  - class_valid_o=1, class_o=best_idx, max_logit_o=best_val, logit_ready_o=0, busy_o=1.
  - Latency: class_valid_o rises on the first cycle after the final accepted beat.
  - Outputs stay stable until result_ack_i=1 is sampled. On that cycle -> IDLE and class_valid_o drops the next cycle. class_o and max_logit_o keep their last values.
  - start_i is ignored in DONE. If start_i and result_ack_i are both high in the same cycle, the block goes to IDLE only and start_i is dropped; the producer re-issues it.
- No arithmetic beyond the signed compare; no width growth.
- The extreme negative value (MSB=1, rest 0) is a legal logit and compares correctly.

Optional Feature:
ARGMAX_HEX_EN:
- When defined: adds output port hex_o [6:0], an active-low seven-segment code for class_o (digits 0-9, A-F).
- hex_o shows dash 7'b0111111 while class_valid_o=0 and the digit of class_o while class_valid_o=1.
- hex_o is registered and resets to the dash.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Vector 0x00000654, 0x00002bd9, 0xfffffaa6, 0xffffefba, 0xffffedcb, 0xfffff75a, 0xfffff8f2, 0x000008c6, 0x000000f7, 0x000001da, with last on beat 9 -> class_o=1, max_logit_o=0x00002bd9, length_error_o=0, class_valid_o high 1 cycle after beat 9.
- All ten logits 0xffff0000 -> class_o=0 (tie goes to lowest index). All 0x80000000 except idx 9 = 0x80000001 -> class_o=9.
- logit_valid_i toggling 1/0 each cycle, ack held off 5 cycles -> same result as contiguous input; outputs stable during all 5 hold cycles; logit_ready_o=0 in DONE.
- logit_last_i on beat 6 -> DONE after 7 beats with length_error_o=1. Ten beats with no last -> DONE after beat 9 with length_error_o=1.
- global_reset pulsed after 4 beats -> all outputs 0, state IDLE; a new start_i plus a full vector gives the correct result. start_i during COLLECT is ignored.
- ARGMAX_HEX_EN defined: result class 7 -> hex_o=7'b1111000; after ack -> hex_o=7'b0111111.
